mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Initiator side of the 8-bit data-memory interface (address, write_data, read_write, read_data).
- Sits between the CPU's load/store path and the byte-wide data memory.
- Accepts byte or halfword load/store requests over a valid/ready handshake.
- Splits halfwords into two sequential little-endian byte accesses and returns load data with a one-cycle response strobe.

Parameters:
- ADDR_W, 8, memory address width; wraps modulo 2^ADDR_W
- RESET_ADDR, 0, value driven on mem_address while idle and after reset

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_write  input  1  1 = store, 0 = load
- req_half  input  1  1 = halfword (2 bytes), 0 = byte
- req_signed  input  1  loads only: 1 = sign-extend byte load to 16 bits
- req_addr  input  ADDR_W  byte address of low byte
- req_wdata  input  16  store data; [7:0] to addr, [15:8] to addr+1
- resp_valid  output  1  one-cycle pulse: access complete
- resp_rdata  output  16  load result, valid while resp_valid=1
- resp_err  output  1  misalignment error (see Optional Feature), valid with resp_valid
- mem_address  output  ADDR_W  to memory address
- mem_write_data  output  8  to memory write_data
- mem_read_write  output  1  to memory read_write; 1 = write at next rising clk
- mem_read_data  input  8  from memory read_data; combinational from mem_address

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- All memory-side outputs are registered.
- Reset values:
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0.
  - mem_address = RESET_ADDR; mem_write_data = 0; mem_read_write = 0.
- States: IDLE, BYTE0, BYTE1, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch the request and go to BYTE0.
  - Drive mem_address = req_addr and mem_write_data = req_wdata[7:0].
  - mem_read_write = req_write, registered so it is valid throughout BYTE0.
- BYTE0:
  - req_ready = 0.
  - Loads capture mem_read_data into rdata[7:0] at the closing edge.
  - Stores are written by memory at the closing edge.
  - If half: go to BYTE1 with mem_address = addr+1 (wraps 255 -> 0) and mem_write_data = wdata[15:8].
  - Otherwise: go to RESP and drop mem_read_write to 0.
- BYTE1: as BYTE0 for the high byte (rdata[15:8]), then go to RESP with mem_read_write = 0.
- RESP:
  - resp_valid = 1 for exactly one cycle, then return to IDLE.
  - req_ready returns to 1 in the IDLE cycle after RESP. RESP does not accept requests.
- Byte load result:
  - resp_rdata[15:8] = {8{rdata[7]}} if req_signed, else 0.
- Store result: resp_rdata = 0.
- Latency from the accept edge to resp_valid:
  - byte: 2 cycles (BYTE0, RESP).
  - halfword: 3 cycles (BYTE0, BYTE1, RESP).
- Responses have no backpressure; the consumer must take resp_valid when it is asserted.
- mem_read_write is never 1 outside BYTE0/BYTE1 of a store. A load never asserts it.
- mem_address is held stable for a full cycle per byte, so the combinational memory read settles before capture.
- Request inputs are ignored while req_ready = 0.
- Reset mid-operation aborts immediately:
  - mem_read_write drops to 0 asynchronously and no response is produced.
  - A halfword store interrupted after BYTE0 leaves only the low byte written. This is accepted.
- Back-to-back operation: a request can be accepted in the IDLE cycle immediately following RESP.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined: a halfword request with req_addr[0] = 1 is accepted, then goes IDLE -> RESP directly with no memory access.
  - mem_read_write stays 0.
  - resp_err = 1, resp_rdata = 0, latency 1 cycle.
- Undefined: resp_err is tied 0. Odd halfwords proceed normally, and address addr+1 wraps at 255.

Decomposition:
- Shared package mem_access_pkg:
  - state encoding (IDLE=2'd0, BYTE0=2'd1, BYTE1=2'd2, RESP=2'd3)
  - width constants DATA_W=8, WORD_W=16
- No sub-module is needed. Sign/zero extension is a small function in the package.

Test Plan:
- Byte store 0xA5 to addr 100 -> mem_read_write = 1 only in BYTE0 with mem_address = 100; resp_valid 2 cycles after accept; memory[100] = 0xA5.
- Halfword store 0x1234 to addr 102, then halfword load addr 102 -> mem[102] = 0x34, mem[103] = 0x12; load resp_rdata = 0x1234 3 cycles after accept.
- Byte load from addr 101 holding 0x80:
  - req_signed = 1 -> resp_rdata = 0xFF80.
  - req_signed = 0 -> resp_rdata = 0x0080.
- Halfword store 0xBEEF to addr 255:
  - Macro undefined -> mem[255] = 0xEF, mem[0] = 0xBE.
  - Macro defined -> resp_err = 1, no write, resp_valid 1 cycle after accept.
- req_valid held high with 3 queued loads -> req_ready low from BYTE0 to RESP; accepts spaced exactly 3 cycles (byte) or 4 cycles (half); no request lost or duplicated.
- rst_n pulsed low during BYTE1 of a halfword store -> mem_read_write = 0 immediately; no resp_valid; only the low byte written; next request behaves normally.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_pkg: state encoding, data widths and load extension helper shared by the memory access controller.
package mem_access_pkg;
    localparam int DATA_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic [WORD_W-1:0] ext_byte(input logic sgn, input logic [DATA_W-1:0] b);
        return {{DATA_W{sgn & b[DATA_W-1]}}, b};
    endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU request/response handshake and byte-wide data-memory bus.
interface mem_access_ctrl_if
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_half;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read_write;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output req_valid, req_write, req_half, req_signed, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_data, mem_read_write
    );

    modport slave (
        input  req_valid, req_write, req_half, req_signed, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_data, mem_read_write
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/halfword load-store initiator for an 8-bit data memory, halfwords as two little-endian bytes.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to reject odd-address halfwords with resp_err instead of accessing memory.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_ctrl_if.slave bus
);
    state_t            r_state;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [WORD_W-1:0] r_resp_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wd;
    logic              r_mem_rw;
    logic              r_half;
    logic              r_signed;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata_hi;
    logic [DATA_W-1:0] r_lo;
    logic [ADDR_W-1:0] r_addr;
    logic              w_accept;
    logic              w_trap;

    assign w_accept = bus.req_valid & r_req_ready;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign w_trap = bus.req_half & bus.req_addr[0];
`else
    assign w_trap = 1'b0;
`endif

    assign bus.req_ready      = r_req_ready;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_rdata     = r_resp_rdata;
    assign bus.resp_err       = r_resp_err;
    assign bus.mem_address    = r_mem_addr;
    assign bus.mem_write_data = r_mem_wd;
    assign bus.mem_read_write = r_mem_rw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_addr   <= RESET_ADDR;
            r_mem_wd     <= '0;
            r_mem_rw     <= 1'b0;
            r_half       <= 1'b0;
            r_signed     <= 1'b0;
            r_write      <= 1'b0;
            r_wdata_hi   <= '0;
            r_lo         <= '0;
            r_addr       <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_req_ready <= 1'b0;
                    r_half      <= bus.req_half;
                    r_signed    <= bus.req_signed;
                    r_write     <= bus.req_write;
                    r_wdata_hi  <= bus.req_wdata[WORD_W-1:DATA_W];
                    r_addr      <= bus.req_addr;
                    if (w_trap) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                    end else begin
                        r_state    <= BYTE0;
                        r_mem_addr <= bus.req_addr;
                        r_mem_wd   <= bus.req_wdata[DATA_W-1:0];
                        r_mem_rw   <= bus.req_write;
                    end
                end
                BYTE0: begin
                    r_lo <= bus.mem_read_data;
                    if (r_half) begin
                        r_state    <= BYTE1;
                        r_mem_addr <= r_addr + ADDR_W'(1);
                        r_mem_wd   <= r_wdata_hi;
                    end else begin
                        r_state      <= RESP;
                        r_mem_rw     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_write ? '0 : ext_byte(r_signed, bus.mem_read_data);
                    end
                end
                BYTE1: begin
                    r_state      <= RESP;
                    r_mem_rw     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= r_write ? '0 : {bus.mem_read_data, r_lo};
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_addr  <= RESET_ADDR;
                    r_mem_wd    <= '0;
                end
            endcase
        end
    end
endmodule
